// File: rtl/game_pkg.sv
// Shared types and constants for the aeroplane-dodging game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int TICK_LINE = 480;

  localparam logic [15:0] SCORE_MAX = 16'hFFFF;

  // Scroll offset wraps inside the visible height; the 11-bit sum avoids overflow.
  function automatic logic [9:0] scroll_wrap(input logic [9:0] cur, input logic [9:0] step);
    logic [10:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= 11'(V_ACTIVE)) sum = sum - 11'(V_ACTIVE);
    return sum[9:0];
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Frame tick decode from the pixel position and rising-edge detect on btn_start.
module game_tick_gen
  import game_pkg::*;
(
  input  logic       clk_d,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_start,
  output logic       frame_tick,
  output logic       start_rise
);

  logic btn_start_q;

  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) btn_start_q <= 1'b0;
    else     btn_start_q <= btn_start;
  end

  assign frame_tick = (pixel_x == 10'd0) && (pixel_y == 10'(TICK_LINE));
  assign start_rise = btn_start & ~btn_start_q;

endmodule

// File: rtl/game_ctrl.sv
// Frame-level game sequencer: plane position, scroll, score and lives update once per frame tick.
// Define GAME_CTRL_LIVES_EN to enable lives, the HIT state and the invulnerability counter.
module game_ctrl
  import game_pkg::*;
#(
  parameter int PLANE_X_INIT = 300,
  parameter int PLANE_X_MIN  = 10,
  parameter int PLANE_X_MAX  = 570,
  parameter int PLANE_STEP   = 4,
  parameter int SCROLL_STEP  = 2,
  parameter int LIVES        = 3,
  parameter int HIT_FRAMES   = 60
) (
  input  logic        clk_d,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        obstacle_px,
  input  logic        plane_px,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output logic [9:0]  plane_x,
  output logic [9:0]  scroll_y,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [1:0]  lives
);

  logic        frame_tick;
  logic        start_rise;
  logic        overlap;
  logic        coll_q;
  logic        start_pend_q;
  game_state_e state_q;
  logic [9:0]  plane_x_q, plane_x_d;
  logic [9:0]  scroll_q, scroll_d;
  logic [15:0] score_q, score_d;
`ifdef GAME_CTRL_LIVES_EN
  logic [1:0]  lives_q;
  logic [7:0]  hit_cnt_q;
`endif

  game_tick_gen u_tick (
    .clk_d      (clk_d),
    .rst        (rst),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .btn_start  (btn_start),
    .frame_tick (frame_tick),
    .start_rise (start_rise)
  );

  assign overlap = video_on & obstacle_px & plane_px;

  // Events seen on the tick cycle itself are carried into the next frame.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      coll_q       <= 1'b0;
      start_pend_q <= 1'b0;
    end else if (frame_tick) begin
      coll_q       <= overlap;
      start_pend_q <= start_rise;
    end else begin
      coll_q       <= coll_q | overlap;
      start_pend_q <= start_pend_q | start_rise;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    plane_x_d = plane_x_q;
    if (btn_left && !btn_right) begin
      if ({1'b0, plane_x_q} < 11'(PLANE_X_MIN + PLANE_STEP)) plane_x_d = 10'(PLANE_X_MIN);
      else                                                     plane_x_d = plane_x_q - 10'(PLANE_STEP);
    end else if (btn_right && !btn_left) begin
      if ({1'b0, plane_x_q} + 11'(PLANE_STEP) > 11'(PLANE_X_MAX)) plane_x_d = 10'(PLANE_X_MAX);
      else                                                        plane_x_d = plane_x_q + 10'(PLANE_STEP);
    end
    scroll_d = scroll_wrap(scroll_q, 10'(SCROLL_STEP));
    score_d  = (score_q == SCORE_MAX) ? score_q : score_q + 16'd1;
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      plane_x_q <= 10'(PLANE_X_INIT);
      scroll_q  <= 10'd0;
      score_q   <= 16'd0;
`ifdef GAME_CTRL_LIVES_EN
      lives_q   <= 2'(LIVES);
      hit_cnt_q <= 8'd0;
`endif
    end else if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          plane_x_q <= 10'(PLANE_X_INIT);
          scroll_q  <= 10'd0;
          score_q   <= 16'd0;
`ifdef GAME_CTRL_LIVES_EN
          lives_q   <= 2'(LIVES);
`endif
          if (start_pend_q) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          plane_x_q <= plane_x_d;
          scroll_q  <= scroll_d;
          score_q   <= score_d;
          if (coll_q) begin
`ifdef GAME_CTRL_LIVES_EN
            lives_q <= lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_q <= ST_OVER;
            end else begin
              state_q   <= ST_HIT;
              hit_cnt_q <= 8'(HIT_FRAMES);
            end
`else
            state_q <= ST_OVER;
`endif
          end
        end
`ifdef GAME_CTRL_LIVES_EN
        ST_HIT: begin
          plane_x_q <= plane_x_d;
          scroll_q  <= scroll_d;
          score_q   <= score_d;
          hit_cnt_q <= hit_cnt_q - 8'd1;
          if (hit_cnt_q == 8'd1) state_q <= ST_PLAY;
        end
`endif
        ST_OVER: begin
          if (start_pend_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign plane_x  = plane_x_q;
  assign scroll_y = scroll_q;
  assign state    = state_q;
  assign score    = score_q;
`ifdef GAME_CTRL_LIVES_EN
  assign lives    = lives_q;
`else
  assign lives    = 2'd1;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl; frames are compressed to a few pixels plus the line-480 tick.
module tb_game_ctrl;

`ifdef GAME_CTRL_LIVES_EN
  localparam int EXP_LIVES = 3;
`else
  localparam int EXP_LIVES = 1;
`endif

  logic        clk_d = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, obstacle_px, plane_px;
  logic        btn_left, btn_right, btn_start;
  logic [9:0]  plane_x, scroll_y;
  logic [1:0]  state;
  logic [15:0] score;
  logic [1:0]  lives;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_score;
  int exp_scroll;

  game_ctrl dut (
    .clk_d       (clk_d),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .obstacle_px (obstacle_px),
    .plane_px    (plane_px),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_start   (btn_start),
    .plane_x     (plane_x),
    .scroll_y    (scroll_y),
    .state       (state),
    .score       (score),
    .lives       (lives)
  );

  always #5 clk_d = ~clk_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic von,
                      input logic ovl, input logic st);
    @(negedge clk_d);
    pixel_x     = x;
    pixel_y     = y;
    video_on    = von;
    obstacle_px = ovl;
    plane_px    = ovl;
    btn_start   = st;
  endtask

  // One frame: three visible pixels, the tick pixel, then one pixel after it.
  task automatic run_frames(input int n, input logic ovl, input logic st);
    for (int f = 0; f < n; f++) begin
      step(10'd20, 10'd100, 1'b1, ovl, st);
      step(10'd21, 10'd100, 1'b1, 1'b0, 1'b0);
      step(10'd22, 10'd100, 1'b1, 1'b0, 1'b0);
      step(10'd0,  10'd480, 1'b0, 1'b0, 1'b0);
      step(10'd1,  10'd480, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic adv(input int n);
    exp_score  = exp_score + n;
    exp_scroll = (exp_scroll + 2 * n) % 480;
  endtask

  initial begin
    rst = 1'b1;
    pixel_x = 10'd0; pixel_y = 10'd100; video_on = 1'b0;
    obstacle_px = 1'b0; plane_px = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
    repeat (3) @(negedge clk_d);
    check("rst_state", state, 0);
    check("rst_plane", plane_x, 300);
    check("rst_scroll", scroll_y, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, EXP_LIVES);
    rst = 1'b0;

    run_frames(3, 1'b0, 1'b0);
    check("idle_state", state, 0);
    check("idle_plane", plane_x, 300);
    check("idle_scroll", scroll_y, 0);
    check("idle_score", score, 0);

    run_frames(1, 1'b0, 1'b1);
    check("start_state", state, 1);
    check("start_score", score, 0);

    btn_right = 1'b1;
    run_frames(100, 1'b0, 1'b0);
    check("right_plane_sat", plane_x, 570);
    check("right_score", score, 100);
    check("right_scroll", scroll_y, 200);

    btn_right = 1'b0; btn_left = 1'b1;
    run_frames(139, 1'b0, 1'b0);
    check("left_plane", plane_x, 14);
    check("scroll_478", scroll_y, 478);
    check("left_score", score, 239);
    run_frames(1, 1'b0, 1'b0);
    check("scroll_wrap", scroll_y, 0);
    check("left_to_min", plane_x, 10);
    run_frames(1, 1'b0, 1'b0);
    check("left_sat_min", plane_x, 10);
    check("scroll_2", scroll_y, 2);
    btn_right = 1'b1;
    run_frames(1, 1'b0, 1'b0);
    check("both_at_min", plane_x, 10);
    btn_left = 1'b0;
    run_frames(1, 1'b0, 1'b0);
    check("right_step", plane_x, 14);
    btn_left = 1'b1;
    run_frames(1, 1'b0, 1'b0);
    check("both_hold", plane_x, 14);
    check("both_score", score, 244);
    btn_left = 1'b0; btn_right = 1'b0;
    exp_score  = 244;
    exp_scroll = 8;

    run_frames(1, 1'b1, 1'b0); adv(1);
    check("coll1_score", score, exp_score);
    check("coll1_scroll", scroll_y, exp_scroll);
`ifdef GAME_CTRL_LIVES_EN
    check("coll1_state", state, 2);
    check("coll1_lives", lives, 2);
    run_frames(1, 1'b1, 1'b0); adv(1);
    check("hit_ignore_state", state, 2);
    check("hit_ignore_lives", lives, 2);
    run_frames(58, 1'b0, 1'b0); adv(58);
    check("hit_59_state", state, 2);
    run_frames(1, 1'b0, 1'b0); adv(1);
    check("hit_end_state", state, 1);
    check("hit_end_lives", lives, 2);
    run_frames(1, 1'b1, 1'b0); adv(1);
    check("coll2_state", state, 2);
    check("coll2_lives", lives, 1);
    run_frames(60, 1'b0, 1'b0); adv(60);
    check("hit2_end_state", state, 1);
    run_frames(1, 1'b1, 1'b0); adv(1);
    check("coll3_lives", lives, 0);
`else
    check("coll1_lives", lives, 1);
`endif
    check("over_state", state, 3);

    run_frames(3, 1'b1, 1'b0);
    check("frozen_state", state, 3);
    check("frozen_score", score, exp_score);
    check("frozen_scroll", scroll_y, exp_scroll);
    check("frozen_plane", plane_x, 14);

    run_frames(1, 1'b0, 1'b1);
    check("over_to_idle", state, 0);
    check("idle_keep_score", score, exp_score);
    run_frames(1, 1'b0, 1'b0);
    check("reinit_lives", lives, EXP_LIVES);
    check("reinit_score", score, 0);
    check("reinit_plane", plane_x, 300);
    check("reinit_scroll", scroll_y, 0);

    run_frames(1, 1'b0, 1'b1);
    check("restart_state", state, 1);
    run_frames(2, 1'b0, 1'b0);
    check("restart_score", score, 2);
`ifdef GAME_CTRL_LIVES_EN
    run_frames(1, 1'b1, 1'b0);
    check("pre_rst_hit", state, 2);
`endif
    step(10'd20, 10'd100, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_scroll", scroll_y, 0);
    check("mid_rst_plane", plane_x, 300);
    check("mid_rst_lives", lives, EXP_LIVES);
    @(negedge clk_d);
    rst = 1'b0;

    step(10'd0,   10'd100, 1'b0, 1'b0, 1'b1);
    step(10'd0,   10'd479, 1'b0, 1'b0, 1'b0);
    step(10'd5,   10'd480, 1'b0, 1'b0, 1'b0);
    step(10'd799, 10'd524, 1'b0, 1'b0, 1'b0);
    check("no_tick_off_line", state, 0);
    step(10'd0,   10'd480, 1'b0, 1'b0, 1'b0);
    step(10'd1,   10'd480, 1'b0, 1'b0, 1'b0);
    check("tick_at_480", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Frame-level game sequencer for the aeroplane-dodging display. Sits beside the pixel generator: watches the pixel stream for plane/obstacle overlap, and once per frame updates the plane position, the obstacle scroll offset, score and lives. The pixel generator consumes `plane_x` and `scroll_y` to draw the next frame. All game state changes happen only at the frame tick, so a frame is never drawn with mixed positions.

## Interface
- `PLANE_X_INIT`, 300: plane x after reset / new game.
- `PLANE_X_MIN`, 10: lowest legal plane x (saturate).
- `PLANE_X_MAX`, 570: highest legal plane x (saturate).
- `PLANE_STEP`, 4: plane x change per frame per held button.
- `SCROLL_STEP`, 2: scroll_y advance per frame; must be < 480.
- `LIVES`, 3: lives at game start, 1..3.
- `HIT_FRAMES`, 60: invulnerability frames after a hit, 1..255.
- `clk_d` in 1: pixel clock.
- `rst` in 1: asynchronous reset, active-high.
- `pixel_x` in 10: current horizontal pixel, 0..799.
- `pixel_y` in 10: current vertical line, 0..524.
- `video_on` in 1: active display area.
- `obstacle_px` in 1: obstacle drawn at current pixel.
- `plane_px` in 1: plane drawn at current pixel.
- `btn_left`, `btn_right`, `btn_start` in 1 each: debounced, synchronized levels.
- `plane_x` out 10: plane left edge.
- `scroll_y` out 10: obstacle vertical offset, 0..479.
- `state` out 2: IDLE=0, PLAY=1, HIT=2, OVER=3.
- `score` out 16: frames survived.
- `lives` out 2: remaining lives.

## Operation
- Frame tick: single-cycle pulse when `pixel_x==0 && pixel_y==480`. All registered outputs update only on the tick cycle.
- Collision flag: set on any cycle with `video_on && obstacle_px && plane_px`. Cleared on the tick cycle after evaluation.
- Start request: rising edge of `btn_start` sets `start_pend`. The flag is consumed (cleared) at the next tick in IDLE or OVER. In PLAY/HIT it is cleared at the tick and ignored.
- IDLE: `plane_x`=PLANE_X_INIT, `scroll_y`=0, `score`=0, `lives`=LIVES. If `start_pend` is set at the tick, go to PLAY; the collision flag is discarded.
- PLAY and HIT, at each tick:
  - `plane_x` moves −STEP on left-only and +STEP on right-only. It does not move with both or neither held. Clamp to [MIN, MAX].
  - `scroll_y` = `scroll_y`+SCROLL_STEP; subtract 480 if the sum is ≥ 480 (compute 11-bit).
  - `score` increments, saturating at 16'hFFFF.
- PLAY with collision flag at the tick: `lives` decrements. If the result is 0, go to OVER. Otherwise go to HIT and load the invulnerability counter with HIT_FRAMES.
- HIT: the collision flag is ignored. The counter decrements per tick; when the counter is 1 at a tick, go to PLAY.
- OVER: all outputs frozen. If `start_pend` is set at the tick, go to IDLE (values reinitialise at the next tick).

## Timing
- Reset values: `state`=IDLE, `plane_x`=PLANE_X_INIT, `scroll_y`=0, `score`=0, `lives`=LIVES. Collision flag, `start_pend` and counter are all 0.
- Outputs change one cycle after the tick cycle (registered on the tick edge) and hold for the whole frame.
- A collision sampled on the tick cycle itself belongs to the next frame. It cannot occur in practice, since `video_on`=0 at line 480.
- A start edge on the tick cycle is latched and acted on at the following tick.
- Reset asserted mid-frame: immediate return to reset values. No tick occurs until the next line-480 crossing after release.

## Configuration
- `GAME_CTRL_LIVES_EN` defined: the lives, HIT state and invulnerability counter operate as above.
- Undefined:
  - `lives` is tied to 1.
  - The HIT state and counter are removed.
  - The first collision in PLAY goes directly to OVER.

## Structure
- Package `game_pkg`:
  - state enum (IDLE/PLAY/HIT/OVER)
  - H_ACTIVE=640, V_ACTIVE=480
  - TICK_LINE=480
  - SCORE_MAX
- Sub-module `game_tick_gen`: produces `frame_tick` from `pixel_x`/`pixel_y`, and the `btn_start` rising-edge pulse.

## Test plan
- Reset, then run 3 frames without start → `state`=0, `plane_x`=300, `scroll_y`=0, `score`=0.
- Start pulse, then hold `btn_right` for 100 frames → `plane_x`=570 (saturated), `score`=100, `scroll_y`=200.
- In PLAY, reach `scroll_y`=478 and advance one frame → `scroll_y`=0. Then hold both buttons → `plane_x` unchanged.
- With `GAME_CTRL_LIVES_EN`, force an overlap pixel in a frame → `lives`=2 and `state`=HIT after the tick. A further overlap during the next 60 frames leaves `lives`=2. `state`=PLAY after 60 ticks.
- Three separated collisions → `state`=OVER with outputs frozen. Start edge → IDLE, then the next tick restores `lives`=3 and `score`=0.
- Assert `rst` mid-frame during HIT → all outputs return to reset values immediately. No tick fires until line 480.
